// File: rtl/ball_ctrl.sv
// Ball step sequencer: step-enable divider, x/y direction bits, wall/paddle/brick
// reflection and miss detection. Optional lives/game-over logic under BALL_CTRL_LIVES_EN.
module ball_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter logic [9:0]  X_MIN    = 10'd0,
  parameter logic [9:0]  X_MAX    = 10'd639,
  parameter logic [9:0]  Y_MIN    = 10'd0,
  parameter logic [9:0]  Y_MAX    = 10'd479,
  parameter logic [2:0]  LIVES    = 3'd3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       brick_x,
  input  logic       brick_y,
  input  logic       paddle_hit,
  output logic       enable,
  output logic       x_du,
  output logic       y_du,
  output logic       ball_rstn,
  output logic       miss,
  output logic       game_over
);

  // state | meaning
  // IDLE  | ball held cleared, waiting for start
  // MOVE  | divider running, issues one step enable per period
  // CHECK | one cycle: evaluate new position, update directions
  // LOST  | one cycle: miss pulse, ball cleared
  // OVER  | no lives left, held until reset (lives build only)
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MOVE  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_LOST  = 3'd3;
`ifdef BALL_CTRL_LIVES_EN
  localparam logic [2:0] S_OVER  = 3'd4;
`endif

  localparam logic [19:0] DIV_PRE = 20'(TICK_DIV - 2);

  logic [2:0]  state, state_n;
  logic [19:0] div, div_n;
  logic        flag_x, flag_x_n;
  logic        flag_y, flag_y_n;
  logic        x_du_n, y_du_n;
  logic        enable_n;
`ifdef BALL_CTRL_LIVES_EN
  logic [2:0]  lives, lives_n;
`endif

  always_comb begin
    state_n  = state;
    div_n    = div;
    x_du_n   = x_du;
    y_du_n   = y_du;
    enable_n = 1'b0;
`ifdef BALL_CTRL_LIVES_EN
    lives_n  = lives;
`endif
    case (state)
      S_IDLE: begin
        div_n = '0;
        if (start) state_n = S_MOVE;
      end
      S_MOVE: begin
        // Once enable is out the step is committed, so CHECK follows even if pause rose.
        if (enable) begin
          div_n   = '0;
          state_n = S_CHECK;
        end else if (!pause) begin
          div_n = div + 20'd1;
          if (div == DIV_PRE) enable_n = 1'b1;
        end
      end
      S_CHECK: begin
        state_n = S_MOVE;
        if (x <= X_MIN)      x_du_n = 1'b1;
        else if (x >= X_MAX) x_du_n = 1'b0;
        else if (flag_x)     x_du_n = ~x_du;
        if (y <= Y_MIN) y_du_n = 1'b1;
        else if (y >= Y_MAX && y_du) begin
          if (paddle_hit) y_du_n = 1'b0;
          else            state_n = S_LOST;
        end else if (flag_y) y_du_n = ~y_du;
      end
      S_LOST: begin
`ifdef BALL_CTRL_LIVES_EN
        lives_n = lives - 3'd1;
        state_n = (lives <= 3'd1) ? S_OVER : S_IDLE;
`else
        state_n = S_IDLE;
`endif
      end
`ifdef BALL_CTRL_LIVES_EN
      S_OVER: state_n = S_OVER;
`endif
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_IDLE) begin
      x_du_n = 1'b1;
      y_du_n = 1'b1;
    end

    // A pulse landing in the CHECK cycle survives into the next period.
    if (state == S_IDLE || state_n == S_IDLE) begin
      flag_x_n = 1'b0;
      flag_y_n = 1'b0;
    end else if (state == S_CHECK) begin
      flag_x_n = brick_x;
      flag_y_n = brick_y;
    end else begin
      flag_x_n = flag_x | brick_x;
      flag_y_n = flag_y | brick_y;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= S_IDLE;
      div       <= '0;
      flag_x    <= 1'b0;
      flag_y    <= 1'b0;
      x_du      <= 1'b1;
      y_du      <= 1'b1;
      enable    <= 1'b0;
      ball_rstn <= 1'b0;
      miss      <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= div_n;
      flag_x    <= flag_x_n;
      flag_y    <= flag_y_n;
      x_du      <= x_du_n;
      y_du      <= y_du_n;
      enable    <= enable_n;
      ball_rstn <= (state_n == S_MOVE) || (state_n == S_CHECK);
      miss      <= (state_n == S_LOST);
    end
  end

`ifdef BALL_CTRL_LIVES_EN
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      lives     <= LIVES;
      game_over <= 1'b0;
    end else begin
      lives     <= lives_n;
      game_over <= (state_n == S_OVER);
    end
  end
`else
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl with a small ball_pos model (TICK_DIV=4, X_MAX=15, Y_MAX=10).
module tb_ball_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0, pause = 1'b0;
  logic       brick_x = 1'b0, brick_y = 1'b0, paddle_hit = 1'b0;
  logic [9:0] bx, by;
  logic [9:0] home_x = 10'd5, home_y = 10'd3;
  logic       enable, x_du, y_du, ball_rstn, miss, game_over;
  int         checks = 0;
  int         failures = 0;

  ball_ctrl #(
    .TICK_DIV(4), .X_MIN(10'd0), .X_MAX(10'd15),
    .Y_MIN(10'd0), .Y_MAX(10'd10), .LIVES(3'd2)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause),
    .x(bx), .y(by), .brick_x(brick_x), .brick_y(brick_y),
    .paddle_hit(paddle_hit), .enable(enable), .x_du(x_du), .y_du(y_du),
    .ball_rstn(ball_rstn), .miss(miss), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // ball_pos stand-in
  always @(posedge clk) begin
    if (!ball_rstn) begin
      bx <= home_x;
      by <= home_y;
    end else if (enable) begin
      bx <= x_du ? bx + 10'd1 : bx - 10'd1;
      by <= y_du ? by + 10'd1 : by - 10'd1;
    end
  end

  task automatic do_reset(input logic [9:0] hx, input logic [9:0] hy);
    start = 1'b0; pause = 1'b0; brick_x = 1'b0; brick_y = 1'b0; paddle_hit = 1'b0;
    home_x = hx; home_y = hy;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
  endtask

  // Leaves the caller at the negedge of cycle 0 (first MOVE cycle).
  task automatic serve();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(10'd5, 10'd3);
    checks++;
    if ({enable, x_du, y_du, ball_rstn, miss, game_over} !== 6'b011000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=011000", {enable, x_du, y_du, ball_rstn, miss, game_over});
    end
  endtask

  task automatic test_serve();
    do_reset(10'd5, 10'd3);
    serve();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (enable !== ((i % 5) == 3)) begin
        failures++;
        $display("FAIL serve_enable cycle=%0d got=%b exp=%b", i, enable, ((i % 5) == 3));
      end
      if (i == 0) begin
        checks++;
        if (ball_rstn !== 1'b1) begin
          failures++;
          $display("FAIL serve_ball_rstn got=%b exp=1", ball_rstn);
        end
      end
    end
    checks++;
    if ({x_du, y_du} !== 2'b11 || bx !== 10'd8) begin
      failures++;
      $display("FAIL serve_dirs_pos got=%b%b x=%0d exp=11 x=8", x_du, y_du, bx);
    end
  endtask

  task automatic test_right_wall();
    do_reset(10'd13, 10'd2);
    serve();
    repeat (10) @(negedge clk);
    checks++;
    if (x_du !== 1'b0 || bx !== 10'd15) begin
      failures++;
      $display("FAIL right_wall_turn got x_du=%b x=%0d exp x_du=0 x=15", x_du, bx);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bx !== 10'd14) begin
      failures++;
      $display("FAIL right_wall_step got x=%0d exp x=14", bx);
    end
    // asynchronous reset mid-operation
    #2 resetn = 1'b1;
    #1;
    checks++;
    if ({enable, x_du, y_du, ball_rstn, miss} !== 5'b01100) begin
      failures++;
      $display("FAIL async_reset got=%b exp=01100", {enable, x_du, y_du, ball_rstn, miss});
    end
    @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic test_pause();
    int seen;
    do_reset(10'd3, 10'd3);
    serve();
    repeat (2) @(negedge clk);
    pause = 1'b1;
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (enable) seen++;
    end
    pause = 1'b0;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL pause_hold got enables=%0d exp=0", seen);
    end
    @(negedge clk);
    checks++;
    if (enable !== 1'b1) begin
      failures++;
      $display("FAIL pause_release got=%b exp=1", enable);
    end
    @(negedge clk);
    checks++;
    if (bx !== 10'd4 || enable !== 1'b0) begin
      failures++;
      $display("FAIL pause_step got x=%0d en=%b exp x=4 en=0", bx, enable);
    end
  endtask

  task automatic test_paddle();
    do_reset(10'd3, 10'd8);
    paddle_hit = 1'b1;
    serve();
    repeat (10) @(negedge clk);
    checks++;
    if (y_du !== 1'b0 || ball_rstn !== 1'b1 || miss !== 1'b0) begin
      failures++;
      $display("FAIL paddle_bounce got y_du=%b rstn=%b miss=%b exp 0 1 0", y_du, ball_rstn, miss);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (by !== 10'd9) begin
      failures++;
      $display("FAIL paddle_step got y=%0d exp=9", by);
    end
  endtask

  task automatic test_miss();
    do_reset(10'd3, 10'd8);
    serve();
    repeat (9) @(negedge clk);
    checks++;
    if (miss !== 1'b0) begin
      failures++;
      $display("FAIL miss_early got=%b exp=0", miss);
    end
    @(negedge clk);
    checks++;
    if ({miss, ball_rstn, enable} !== 3'b100) begin
      failures++;
      $display("FAIL miss_pulse got=%b exp=100", {miss, ball_rstn, enable});
    end
    @(negedge clk);
    checks++;
    if ({miss, ball_rstn, x_du, y_du, game_over} !== 5'b00110) begin
      failures++;
      $display("FAIL miss_idle got=%b exp=00110", {miss, ball_rstn, x_du, y_du, game_over});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ball_rstn !== 1'b0 || enable !== 1'b0) begin
      failures++;
      $display("FAIL miss_stays_idle got rstn=%b en=%b exp 0 0", ball_rstn, enable);
    end
  endtask

  task automatic test_wall_brick();
    do_reset(10'd1, 10'd2);
    serve();
    @(negedge clk);
    brick_x = 1'b1;
    @(negedge clk);
    brick_x = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (x_du !== 1'b0) begin
      failures++;
      $display("FAIL brick_flip got x_du=%b exp=0", x_du);
    end
    repeat (6) @(negedge clk);
    brick_x = 1'b1;
    @(negedge clk);
    brick_x = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (x_du !== 1'b1 || bx !== 10'd0) begin
      failures++;
      $display("FAIL wall_brick got x_du=%b x=%0d exp x_du=1 x=0", x_du, bx);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (x_du !== 1'b1 || bx !== 10'd1) begin
      failures++;
      $display("FAIL wall_brick_flag_clear got x_du=%b x=%0d exp x_du=1 x=1", x_du, bx);
    end
  endtask

  task automatic test_brick_in_check();
    do_reset(10'd3, 10'd3);
    serve();
    repeat (4) @(negedge clk);
    brick_y = 1'b1;
    @(negedge clk);
    brick_y = 1'b0;
    checks++;
    if (y_du !== 1'b1) begin
      failures++;
      $display("FAIL brick_check_same got y_du=%b exp=1", y_du);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (y_du !== 1'b0) begin
      failures++;
      $display("FAIL brick_check_kept got y_du=%b exp=0", y_du);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (y_du !== 1'b0 || by !== 10'd4) begin
      failures++;
      $display("FAIL brick_check_clear got y_du=%b y=%0d exp y_du=0 y=4", y_du, by);
    end
  endtask

`ifdef BALL_CTRL_LIVES_EN
  task automatic test_lives();
    do_reset(10'd3, 10'd8);
    for (int k = 0; k < 2; k++) begin
      serve();
      repeat (11) @(negedge clk);
    end
    checks++;
    if (game_over !== 1'b1 || ball_rstn !== 1'b0) begin
      failures++;
      $display("FAIL lives_over got go=%b rstn=%b exp 1 0", game_over, ball_rstn);
    end
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    checks++;
    if (game_over !== 1'b1 || ball_rstn !== 1'b0 || enable !== 1'b0) begin
      failures++;
      $display("FAIL lives_start_ignored got go=%b rstn=%b en=%b exp 1 0 0", game_over, ball_rstn, enable);
    end
    do_reset(10'd3, 10'd8);
    checks++;
    if (game_over !== 1'b0) begin
      failures++;
      $display("FAIL lives_reset got go=%b exp=0", game_over);
    end
  endtask
`else
  task automatic test_no_lives();
    do_reset(10'd3, 10'd8);
    for (int k = 0; k < 4; k++) begin
      serve();
      repeat (11) @(negedge clk);
    end
    checks++;
    if (game_over !== 1'b0) begin
      failures++;
      $display("FAIL no_lives_game_over got=%b exp=0", game_over);
    end
    serve();
    checks++;
    if (ball_rstn !== 1'b1) begin
      failures++;
      $display("FAIL no_lives_reserve got rstn=%b exp=1", ball_rstn);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_serve();
    test_right_wall();
    test_pause();
    test_paddle();
    test_miss();
    test_wall_brick();
    test_brick_in_check();
`ifdef BALL_CTRL_LIVES_EN
    test_lives();
`else
    test_no_lives();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
